ro_freq_counter: RTL
====================

// Module: ro_freq_counter
// PURPOSE
//  Parametrised ring-oscillator frequency meter for the user area. Selects one of N_OSC oscillator
//  outputs, counts its rising edges over a programmable gate window of wb_clk_i cycles, and reports
//  the count over Wishbone. Successor to the fixed 16:1 oscillator mux; sits behind the wishbone
//  decoder in the user project wrapper, with its interrupt on user_irq[0].
// PARAMETERS
//  N_OSC      16            number of oscillator inputs
//  SEL_W      4             select width, = clog2(N_OSC)
//  CNT_W      24            edge counter width (saturating)
//  GATE_W     20            gate length register width
//  BASE_ADDR  32'h3000_0000 wishbone base; block decodes wbs_adr_i[31:4]
// PORTS
//  wb_clk_i   in   1        system clock
//  wb_rst_i   in   1        async reset, active-high
//  wbs_cyc_i  in   1        wishbone cycle
//  wbs_stb_i  in   1        wishbone strobe
//  wbs_we_i   in   1        write enable
//  wbs_sel_i  in   4        byte lanes (ignored: full-word access only)
//  wbs_adr_i  in   32       address; word index = [3:2]
//  wbs_dat_i  in   32       write data
//  wbs_ack_o  out  1        ack
//  wbs_dat_o  out  32       read data
//  osc_i      in   N_OSC    raw oscillator outputs (async to wb_clk_i)
//  irq_o      out  1        level interrupt = done & irq_en
// BEHAVIOUR
//  Reset: every output 0; all regs 0; FSM IDLE; sel 0, gate 0, count 0.
//  Regs: 0 CTRL  [0] start (W, self-clearing, reads 0), [1] irq_en, [8+:SEL_W] sel
//        1 GATE  [GATE_W-1:0] gate length G in wb_clk_i cycles
//        2 COUNT [CNT_W-1:0] RO, result of last measurement
//        3 STAT  [0] busy (RO), [1] done (W1C), [2] ovf (W1C)
//  Bus: stb&cyc&address hit & !ack -> ack high exactly 1 cycle later for 1 cycle; read data valid
//   with ack. Miss -> no ack. Unused bits read 0.
//  Sampling: osc_i[sel] -> 2-flop synchroniser -> edge flop; rising edge = q2 & !q3.
//   Valid for f_osc < f_clk/2; higher frequencies alias (external divider required).
//  FSM: IDLE -> SETTLE on start write (ack cycle T) -> 3 cycles flush sync chain, counter cleared
//   -> GATE: count edges for exactly G cycles -> IDLE: COUNT latched, done=1, busy=0.
//   done asserts at cycle T+4+G. busy=1 in SETTLE and GATE.
//  Boundaries:
//   G=0: SETTLE then straight to IDLE, COUNT=0, done=1.
//   counter reaching 2^CNT_W-1 holds there, ovf=1.
//   start while busy: ignored. CTRL.sel/GATE writes while busy: ignored (irq_en still writes).
//   start also clears done and ovf. W1C on same cycle as hardware set: set wins.
//   wb_rst_i mid-measurement: immediate return to reset state, no done.
// CONFIGURATION
//  RO_CONT_EN defined: CTRL[2] cont. With cont=1, on reaching IDLE the FSM re-enters SETTLE next
//   cycle (done still pulses set, COUNT updates every 4+G+1 cycles); clearing cont finishes the
//   current window and stops. Without the macro, CTRL[2] reads 0 and every measurement is single-shot.
// TESTING
//  1 reset mid-GATE, sel=5 G=100 -> all outputs 0, STAT=0, COUNT=0 after release.
//  2 osc_i[3] = clk/4 square, sel=3, G=400, start -> done at T+404, COUNT=100 (+/-1), irq_o=1 iff irq_en.
//  3 G=0, start -> COUNT=0, done=1 at T+4; W1C done -> irq_o drops the cycle after ack.
//  4 CNT_W=8, osc=clk/4, G=2000 -> COUNT=255, ovf=1; next start clears ovf.
//  5 start/sel write while busy -> busy unchanged, sel unchanged, finishes with original channel.
//  6 RO_CONT_EN, cont=1, G=10 -> COUNT updates every 15 cycles; cont=0 -> stops after current window.

Source files
------------

// File: rtl/ro_freq_counter_if.sv
// Wishbone slave bundle for the ring-oscillator frequency meter.
// Signal names follow the Caravel user-area wishbone port names.
interface ro_freq_counter_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency meter: counts rising edges of osc_i[sel] over a gate window.
// Optional macro RO_CONT_EN adds CTRL[2] cont for back-to-back continuous measurements.
module ro_freq_counter #(
  parameter int unsigned N_OSC     = 16,
  parameter int unsigned SEL_W     = 4,
  parameter int unsigned CNT_W     = 24,
  parameter int unsigned GATE_W    = 20,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  ro_freq_counter_if.slave wbs,
  input  logic [N_OSC-1:0] osc_i,
  output logic             irq_o
);

  typedef enum logic [1:0] {StIdle, StSettle, StGate} state_e;

  localparam logic [CNT_W-1:0]  CntMax  = '1;
  localparam logic [CNT_W-1:0]  CntOne  = CNT_W'(1);
  localparam logic [GATE_W-1:0] GateOne = GATE_W'(1);

  state_e             state_q, state_d;
  logic [1:0]         scnt_q, scnt_d;
  logic [GATE_W-1:0]  gcnt_q, gcnt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [GATE_W-1:0]  gate_q, gate_d;
  logic               irq_en_q, irq_en_d;
  logic               start_q, start_d;
  logic               fin_q, fin_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [2:0]         sync_q, sync_d;
  logic               ack_q, ack_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               irq_q, irq_d;

`ifdef RO_CONT_EN
  logic cont_q, cont_d;
`else
  logic cont_q;
  assign cont_q = 1'b0;
`endif

  logic              req, hit, busy, lock, rise;
  logic [1:0]        idx;
  logic [31:0]       wdat, rmux;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              unused_bus;

  assign hit  = (wbs.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
  assign req  = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit & ~ack_q;
  assign idx  = wbs.wbs_adr_i[3:2];
  assign wdat = wbs.wbs_dat_i;
  assign busy = (state_q != StIdle);
  // A pending start counts as busy so config cannot change under a launching measurement.
  assign lock = busy | start_q;
  assign rise = sync_q[1] & ~sync_q[2];
  assign cnt_nxt = (rise && cnt_q != CntMax) ? cnt_q + CntOne : cnt_q;

  assign unused_bus = ^{wbs.wbs_sel_i, wbs.wbs_adr_i[1:0], wbs.wbs_dat_i};

  always_comb begin
    rmux = '0;
    unique case (idx)
      2'd0: begin
        rmux[1]         = irq_en_q;
        rmux[2]         = cont_q;
        rmux[8 +: SEL_W] = sel_q;
      end
      2'd1: rmux[GATE_W-1:0] = gate_q;
      2'd2: rmux[CNT_W-1:0]  = result_q;
      2'd3: rmux[2:0]        = {ovf_q, done_q, busy};
      default: rmux = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    scnt_d   = scnt_q;
    gcnt_d   = gcnt_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    sel_d    = sel_q;
    gate_d   = gate_q;
    irq_en_d = irq_en_q;
    start_d  = 1'b0;
    fin_d    = 1'b0;
    done_d   = done_q;
    ovf_d    = ovf_q;
`ifdef RO_CONT_EN
    cont_d   = cont_q;
`endif
    sync_d   = {sync_q[1:0], osc_i[sel_q]};
    ack_d    = req;
    rdata_d  = (req && !wbs.wbs_we_i) ? rmux : 32'h0;
    irq_d    = done_q & irq_en_q;

    if (req && wbs.wbs_we_i) begin
      unique case (idx)
        2'd0: begin
          irq_en_d = wdat[1];
`ifdef RO_CONT_EN
          cont_d   = wdat[2];
`endif
          if (!lock) begin
            sel_d = wdat[8 +: SEL_W];
            if (wdat[0]) begin
              start_d = 1'b1;
              done_d  = 1'b0;
              ovf_d   = 1'b0;
            end
          end
        end
        2'd1: if (!lock) gate_d = wdat[GATE_W-1:0];
        2'd3: begin
          if (wdat[1]) done_d = 1'b0;
          if (wdat[2]) ovf_d  = 1'b0;
        end
        default: ;
      endcase
    end

    // Continuous mode relaunches on the first idle cycle after a window completes.
    if (state_q == StIdle && fin_q && cont_q) begin
      start_d = 1'b1;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end

    // Hardware updates come last so a same-cycle W1C loses to a set.
    unique case (state_q)
      StIdle: begin
        if (start_q) begin
          state_d = StSettle;
          scnt_d  = 2'd0;
        end
      end
      StSettle: begin
        cnt_d = '0;
        if (scnt_q == 2'd2) begin
          if (gate_q == '0) begin
            state_d  = StIdle;
            result_d = '0;
            done_d   = 1'b1;
            fin_d    = 1'b1;
          end else begin
            state_d = StGate;
            gcnt_d  = '0;
          end
        end else begin
          scnt_d = scnt_q + 2'd1;
        end
      end
      StGate: begin
        cnt_d  = cnt_nxt;
        gcnt_d = gcnt_q + GateOne;
        if (rise && cnt_nxt == CntMax) ovf_d = 1'b1;
        if (gcnt_q == gate_q - GateOne) begin
          state_d  = StIdle;
          result_d = cnt_nxt;
          done_d   = 1'b1;
          fin_d    = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= StIdle;
      scnt_q   <= '0;
      gcnt_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      sel_q    <= '0;
      gate_q   <= '0;
      irq_en_q <= 1'b0;
      start_q  <= 1'b0;
      fin_q    <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef RO_CONT_EN
      cont_q   <= 1'b0;
`endif
      sync_q   <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      scnt_q   <= scnt_d;
      gcnt_q   <= gcnt_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      sel_q    <= sel_d;
      gate_q   <= gate_d;
      irq_en_q <= irq_en_d;
      start_q  <= start_d;
      fin_q    <= fin_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
`ifdef RO_CONT_EN
      cont_q   <= cont_d;
`endif
      sync_q   <= sync_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  assign wbs.wbs_ack_o = ack_q;
  assign wbs.wbs_dat_o = rdata_q;
  assign irq_o         = irq_q;

endmodule
